// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the multi-cycle integer divider: FSM state
//   encoding, widths derived from the 32-bit operand size, and the
//   ready/start encodings used by the EX stage handshake.
// ---------------------------------------------------------------------------
package div_pkg;

    // Operand width and the widths derived from it
    localparam int DIV_DATA_W  = 32;
    localparam int DIV_WORK_W  = 2 * DIV_DATA_W + 1;
    localparam int DIV_CNT_W   = 6;

    // Number of shift-subtract steps for a full quotient
    localparam logic [DIV_CNT_W-1:0] DIV_STEPS = 6'd32;

    // Handshake encodings
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div
//   Multi-cycle restoring divider for the EX stage. Signed division works on
//   operand magnitudes and fixes the result signs at the end; a zero divisor
//   short-circuits to an all-zero result. The result stays on result_o while
//   ready_o is high and EX keeps start_i asserted.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   signed_div_i : 1 = signed divide, 0 = unsigned, sampled with start_i
//   opdata1_i    : dividend, sampled with start_i
//   opdata2_i    : divisor, sampled with start_i
//   start_i      : request, held by EX until ready_o is seen
//   annul_i      : flush, aborts any operation in progress
//   result_o     : {remainder, quotient}, valid while ready_o = 1
//   ready_o      : registered result-valid flag
//   stallreq_o   : combinational stall request to the pipeline controller
// ---------------------------------------------------------------------------
module div
    import div_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    div_state_e                  state_q, state_d;
    logic [DIV_CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIV_WORK_W-1:0]       work_q, work_d;
    logic [DIV_DATA_W-1:0]       divisor_q, divisor_d;
    logic                        neg_quot_q, neg_quot_d;
    logic                        neg_rem_q, neg_rem_d;
    logic [2*DIV_DATA_W-1:0]     result_q, result_d;
    logic                        ready_q, ready_d;

    logic [DIV_DATA_W-1:0]       mag_a;
    logic [DIV_DATA_W-1:0]       mag_b;
    logic                        step_ge;
    logic [DIV_DATA_W-1:0]       step_sub;
    logic [DIV_DATA_W-1:0]       quot_raw;
    logic [DIV_DATA_W-1:0]       rem_raw;
    logic [DIV_DATA_W-1:0]       quot_fix;
    logic [DIV_DATA_W-1:0]       rem_fix;

    // The stall request deliberately ignores the FSM state so EX stalls from
    // the very cycle it raises start_i.
    assign stallreq_o = start_i & ~ready_q & ~annul_i;
    assign ready_o    = ready_q;
    assign result_o   = result_q;

    // Operand magnitudes are taken at launch so the iterative core only ever
    // sees unsigned values.
    always_comb begin
        mag_a = opdata1_i;
        mag_b = opdata2_i;
        if (signed_div_i && opdata1_i[DIV_DATA_W-1]) begin
            mag_a = ~opdata1_i + 32'd1;
        end
        if (signed_div_i && opdata2_i[DIV_DATA_W-1]) begin
            mag_b = ~opdata2_i + 32'd1;
        end
    end

    // One restoring step. The partial remainder lives in work_q[64:32]; it can
    // briefly need 33 bits after the shift, hence the wide compare. The low 32
    // bits of the subtraction are exact whenever the compare succeeds.
    always_comb begin
        step_ge  = work_q[DIV_WORK_W-1:DIV_DATA_W] >= {1'b0, divisor_q};
        step_sub = work_q[2*DIV_DATA_W-1:DIV_DATA_W] - divisor_q;
    end

    // After 32 steps the quotient bits have been shifted into the low half and
    // the remainder sits one bit above the middle.
    always_comb begin
        quot_raw = work_q[DIV_DATA_W-1:0];
        rem_raw  = work_q[DIV_WORK_W-1:DIV_DATA_W+1];
        quot_fix = neg_quot_q ? (~quot_raw + 32'd1) : quot_raw;
        rem_fix  = neg_rem_q  ? (~rem_raw  + 32'd1) : rem_raw;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        work_d     = {32'd0, mag_a, 1'b0};
                        divisor_d  = mag_b;
                        neg_quot_d = signed_div_i & (opdata1_i[DIV_DATA_W-1] ^ opdata2_i[DIV_DATA_W-1]);
                        neg_rem_d  = signed_div_i & opdata1_i[DIV_DATA_W-1];
                    end
                end
            end

            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    state_d  = DIV_END;
                    ready_d  = DIV_RESULT_READY;
                    result_d = '0;
                end
            end

            // A flush wins even on the cycle the last step would complete.
            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    cnt_d    = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end else if (cnt_q == DIV_STEPS) begin
                    state_d  = DIV_END;
                    cnt_d    = '0;
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_fix, quot_fix};
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (step_ge) begin
                        work_d = {step_sub, work_q[DIV_DATA_W-1:0], 1'b1};
                    end else begin
                        work_d = {work_q[DIV_WORK_W-2:0], 1'b0};
                    end
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    state_d  = DIV_FREE;
                    ready_d  = DIV_RESULT_NOT_READY;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DIV_RESULT_NOT_READY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// ---------------------------------------------------------------------------
// tb_div
//   Self-checking bench for the divider: a table of directed vectors, a few
//   hand-written flush/reset sequences and randomized operations checked
//   against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    div #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer division on widened values
    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // One full divide transaction with start held until ready, then released
    task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp, input int expLat);
        int   edges;
        logic stallOk;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        #1;
        checkOutput({name, " stall_at_start"}, 64'(stallreq_o), 64'd1);
        edges   = 0;
        stallOk = 1'b1;
        while (edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o === 1'b1) break;
            if (stallreq_o !== 1'b1) stallOk = 1'b0;
        end
        checkOutput({name, " latency"}, 64'(edges - 1), 64'(expLat));
        checkOutput({name, " result"}, result_o, exp);
        checkOutput({name, " stall_while_busy"}, 64'(stallOk), 64'd1);
        checkOutput({name, " stall_when_ready"}, 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({name, " hold_ready"}, 64'(ready_o), 64'd1);
        checkOutput({name, " hold_result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, " release_ready"}, 64'(ready_o), 64'd0);
        checkOutput({name, " release_result"}, result_o, 64'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic        quiet;

        vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2] = '{1'b0, 32'h00001234,   32'd0,        64'h0,                 1};
        vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[4] = '{1'b1, 32'hFFFFFF9C,   32'd7,        64'hFFFFFFFE_FFFFFFF2, 33};
        vecs[5] = '{1'b1, 32'd100,        32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'h80000001, 64'h7FFFFFFE_00000001, 33};
        vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'h00000002, 64'h00000001_7FFFFFFC, 33};

        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        checkOutput("reset ready", 64'(ready_o), 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        checkOutput("reset stall", 64'(stallreq_o), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle ready", 64'(ready_o), 64'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Flush after ten steps: no result may ever appear
        $display("[TB] annul sequence");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        #1;
        checkOutput("annul stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("annul ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        quiet   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0 || result_o !== 64'd0) quiet = 1'b0;
        end
        checkOutput("annul no_result", 64'(quiet), 64'd1);
        applyStimulus("after_annul 5/5", 1'b0, 32'd5, 32'd5, 64'h00000000_00000001, 33);

        // Reset in the middle of the iteration
        $display("[TB] reset mid-operation");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset ready", 64'(ready_o), 64'd0);
        checkOutput("midreset result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        applyStimulus("after_reset 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Reset while a result is being presented clears it at once
        $display("[TB] reset while ready");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd77;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("endreset pre_ready", 64'(ready_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("endreset ready", 64'(ready_o), 64'd0);
        checkOutput("endreset stall", 64'(stallreq_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        #2;
        rst = 1'b1;

        $display("[TB] randomized operations");
        for (int n = 0; n < 150; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                3:       b = a;
                default: b = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d", n), sgn, a, b, refDiv(sgn, a, b), (b == 32'd0) ? 1 : 33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
